// File: rtl/ps2_digit_tx_pkg.sv
// Shared constants, FSM state type and digit->scan-code lookup for the
// PS/2 digit transmitter. PS2_DIGIT_TX_BREAK_EN enables the break sequence.
package ps2_pkg;

  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;

`ifdef PS2_DIGIT_TX_BREAK_EN
  localparam logic [7:0] PS2_BREAK = 8'hF0;
`endif

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2,
    GAP    = 2'd3
  } ps2_state_t;

  // Out-of-range digits map to 0x00; callers gate on digit <= 9.
  function automatic logic [7:0] digit_to_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_to_code = KEY_0;
      4'd1:    digit_to_code = KEY_1;
      4'd2:    digit_to_code = KEY_2;
      4'd3:    digit_to_code = KEY_3;
      4'd4:    digit_to_code = KEY_4;
      4'd5:    digit_to_code = KEY_5;
      4'd6:    digit_to_code = KEY_6;
      4'd7:    digit_to_code = KEY_7;
      4'd8:    digit_to_code = KEY_8;
      4'd9:    digit_to_code = KEY_9;
      default: digit_to_code = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_digit_tx_if.sv
// Request/status and PS/2 line bundle of the digit transmitter.
interface ps2_digit_tx_if;
  logic [3:0] digit;
  logic       send;
  logic       ready;
  logic       err;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] last_code;

  modport master (
    output digit, send,
    input  ready, err, ps2_clk, ps2_data, last_code
  );

  modport slave (
    input  digit, send,
    output ready, err, ps2_clk, ps2_data, last_code
  );
endinterface

// File: rtl/ps2_digit_tx_byte_tx.sv
// Serialises one byte as an 11-bit PS/2 device frame followed by an idle gap.
// A start presented on the last gap cycle chains the next frame with no
// extra idle cycle.
module ps2_byte_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYCLES = 2500,
  parameter int GAP_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       idle,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int HW = ($clog2(HALF_CYCLES) > 0) ? $clog2(HALF_CYCLES) : 1;
  localparam int GW = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t      state, state_next;
  logic [HW-1:0]   half_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [3:0]      bit_idx;
  logic [10:0]     frame;
  logic            half_exp, gap_exp, load;

  assign half_exp = (half_cnt == HALF_LAST);
  assign gap_exp  = (gap_cnt == GAP_LAST);
  assign load     = start && ((state == IDLE) || (state == GAP && gap_exp));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (load) state_next = BIT_HI;
      BIT_HI: if (half_exp) state_next = BIT_LO;
      BIT_LO: if (half_exp) state_next = (bit_idx == BIT_LAST) ? GAP : BIT_HI;
      GAP:    if (gap_exp) state_next = load ? BIT_HI : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame shift source and half-period / gap / bit counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame    <= '1;
      bit_idx  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
    end else if (load) begin
      frame    <= {1'b1, ~^tx_byte, tx_byte, 1'b0};
      bit_idx  <= '0;
      half_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        BIT_HI: half_cnt <= half_exp ? '0 : half_cnt + 1'b1;
        BIT_LO: begin
          half_cnt <= half_exp ? '0 : half_cnt + 1'b1;
          if (half_exp) bit_idx <= bit_idx + 1'b1;
        end
        GAP:    gap_cnt <= gap_exp ? '0 : gap_cnt + 1'b1;
        default: begin
          half_cnt <= '0;
          gap_cnt  <= '0;
        end
      endcase
    end
  end

  // Line and status outputs decoded from state; data only moves on BIT_HI entry.
  always_comb begin
    idle     = (state == IDLE);
    done     = (state == GAP) && gap_exp;
    ps2_clk  = (state != BIT_LO);
    ps2_data = 1'b1;
    if (state == BIT_HI || state == BIT_LO) ps2_data = frame[bit_idx];
  end

endmodule

// File: rtl/ps2_digit_tx.sv
// PS/2 digit keystroke transmitter: accepts a digit, looks up its scan code
// and emits make (and, with PS2_DIGIT_TX_BREAK_EN, break F0+code) frames.
module ps2_digit_tx
  import ps2_pkg::*;
#(
  parameter int HALF_CYCLES = 2500,
  parameter int GAP_CYCLES  = 5000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_digit_tx_if.slave bus
);

  logic       idle, done, start, accept, more;
  logic [7:0] code_next, tx_byte, last_code;
  logic       err;

  assign code_next = digit_to_code(bus.digit);
  assign accept    = idle && bus.send && (bus.digit <= 4'd9);

`ifdef PS2_DIGIT_TX_BREAK_EN
  // byte_idx counts frames already finished for the current keystroke.
  logic [1:0] byte_idx;

  assign more    = (byte_idx != 2'd2);
  assign tx_byte = accept ? code_next : ((byte_idx == 2'd0) ? PS2_BREAK : last_code);

  // Byte sequencing: code, F0, code.
  always_ff @(posedge clk) begin
    if (reset)             byte_idx <= '0;
    else if (accept)       byte_idx <= '0;
    else if (done && more) byte_idx <= byte_idx + 1'b1;
  end
`else
  assign more    = 1'b0;
  assign tx_byte = code_next;
`endif

  assign start = accept || (done && more);

  // Acceptance bookkeeping and invalid-digit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_code <= 8'h00;
      err       <= 1'b0;
    end else begin
      err <= idle && bus.send && (bus.digit > 4'd9);
      if (accept) last_code <= code_next;
    end
  end

  ps2_byte_tx #(
    .HALF_CYCLES(HALF_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_byte_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_byte (tx_byte),
    .idle    (idle),
    .done    (done),
    .ps2_clk (bus.ps2_clk),
    .ps2_data(bus.ps2_data)
  );

  assign bus.ready     = idle;
  assign bus.err       = err;
  assign bus.last_code = last_code;

endmodule

// File: tb/tb_ps2_digit_tx.sv
// Bench for ps2_digit_tx: host-side line monitor plus expected-byte scoreboard.
module tb_ps2_digit_tx;

  localparam int H = 4;
  localparam int G = 8;
`ifdef PS2_DIGIT_TX_BREAK_EN
  localparam int NFR = 3;
`else
  localparam int NFR = 1;
`endif
  localparam int BUSY = NFR * (22 * H + G);

  typedef struct {
    logic [10:0] bits;
    logic        unstable;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  ps2_digit_tx_if bus ();

  ps2_digit_tx #(.HALF_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          fall_cnt = 0;
  logic [7:0]  exp_last = 8'h00;
  logic [7:0]  exp_q[$];
  frame_t      rx_q[$];
  logic [7:0]  key_tab[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Host model: capture data at each ps2_clk fall, flag any data change
  // while the clock is low, hand complete frames to the scoreboard.
  int          nb = 0;
  logic [10:0] sh = '0;
  logic        cur = 1'b1;
  logic        prev_clk = 1'b1;
  logic        unstable = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      nb = 0; unstable = 1'b0; prev_clk = 1'b1;
    end else begin
      if (prev_clk && !bus.ps2_clk) begin
        cur = bus.ps2_data;
        if (nb < 11) sh[nb] = cur;
        nb++;
        fall_cnt++;
      end else if (!prev_clk && !bus.ps2_clk && bus.ps2_data !== cur) begin
        unstable = 1'b1;
      end else if (!prev_clk && bus.ps2_clk && nb == 11) begin
        rx_q.push_back('{bits: sh, unstable: unstable});
        nb = 0;
        unstable = 1'b0;
      end
      prev_clk = bus.ps2_clk;
    end
  end

  task automatic drive_send(input logic [3:0] d);
    @(negedge clk);
    bus.digit = d;
    bus.send  = 1'b1;
    @(negedge clk);
    bus.send  = 1'b0;
  endtask

  // Counts ready=0 cycles from the current negedge; bounded.
  task automatic wait_idle(output int busy);
    busy = 0;
    while (bus.ready !== 1'b1 && busy < 4000) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.send = 1'b0; bus.digit = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    n_cmp++; if (bus.ps2_clk !== 1'b1) begin n_err++; $display("FAIL reset_ps2_clk got=%b exp=1", bus.ps2_clk); end
    n_cmp++; if (bus.ps2_data !== 1'b1) begin n_err++; $display("FAIL reset_ps2_data got=%b exp=1", bus.ps2_data); end
    n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    n_cmp++; if (bus.last_code !== 8'h00) begin n_err++; $display("FAIL reset_last_code got=%h exp=00", bus.last_code); end
  endtask

  task automatic push_key(input logic [7:0] code);
    exp_q.push_back(code);
`ifdef PS2_DIGIT_TX_BREAK_EN
    exp_q.push_back(8'hF0);
    exp_q.push_back(code);
`endif
  endtask

  // Drains the scoreboard against captured frames.
  task automatic check_frames(input string tag);
    logic [7:0] e;
    frame_t     f;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rx_q.size() == 0) begin
        n_err++; $display("FAIL %s_missing_frame got=none exp=%h", tag, e);
      end else begin
        f = rx_q.pop_front();
        if (f.bits[8:1] !== e) begin n_err++; $display("FAIL %s_data got=%h exp=%h", tag, f.bits[8:1], e); end
        n_cmp++; if (f.bits[9] !== ~^e) begin n_err++; $display("FAIL %s_parity byte=%h got=%b exp=%b", tag, e, f.bits[9], ~^e); end
        n_cmp++; if ({f.bits[10], f.bits[0]} !== 2'b10) begin n_err++; $display("FAIL %s_stop_start got=%b exp=10", tag, {f.bits[10], f.bits[0]}); end
        n_cmp++; if (f.unstable !== 1'b0) begin n_err++; $display("FAIL %s_data_stable_low got=%b exp=0", tag, f.unstable); end
      end
    end
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL %s_extra_frames got=%0d exp=0", tag, rx_q.size()); rx_q.delete(); end
  endtask

  task automatic test_digit(input logic [3:0] d);
    int busy;
    push_key(key_tab[d]);
    drive_send(d);
    exp_last = key_tab[d];
    wait_idle(busy);
    n_cmp++; if (busy != BUSY) begin n_err++; $display("FAIL digit%0d_busy got=%0d exp=%0d", d, busy, BUSY); end
    repeat (2) @(negedge clk);
    check_frames($sformatf("digit%0d", d));
    n_cmp++; if (bus.last_code !== exp_last) begin n_err++; $display("FAIL digit%0d_last_code got=%h exp=%h", d, bus.last_code, exp_last); end
  endtask

  task automatic test_invalid();
    int falls0, errs;
    falls0 = fall_cnt;
    @(negedge clk);
    bus.digit = 4'd12; bus.send = 1'b1;
    @(negedge clk);
    bus.send = 1'b0;
    n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL invalid_err_pulse got=%b exp=1", bus.err); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL invalid_ready got=%b exp=1", bus.ready); end
    errs = 0;
    repeat (30) begin @(negedge clk); if (bus.err === 1'b1) errs++; end
    n_cmp++; if (errs != 0) begin n_err++; $display("FAIL invalid_err_width extra_cycles=%0d exp=0", errs); end
    n_cmp++; if (fall_cnt != falls0) begin n_err++; $display("FAIL invalid_clk_edges got=%0d exp=0", fall_cnt - falls0); end
    n_cmp++; if (bus.last_code !== exp_last) begin n_err++; $display("FAIL invalid_last_code got=%h exp=%h", bus.last_code, exp_last); end
  endtask

  task automatic test_reset_mid();
    drive_send(4'd3);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ps2_clk !== 1'b1) begin n_err++; $display("FAIL midrst_ps2_clk got=%b exp=1", bus.ps2_clk); end
    n_cmp++; if (bus.ps2_data !== 1'b1) begin n_err++; $display("FAIL midrst_ps2_data got=%b exp=1", bus.ps2_data); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got=%b exp=1", bus.ready); end
    n_cmp++; if (bus.last_code !== 8'h00) begin n_err++; $display("FAIL midrst_last_code got=%h exp=00", bus.last_code); end
    @(negedge clk);
    reset = 1'b0;
    exp_last = 8'h00;
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL midrst_partial_frame got=%0d exp=0", rx_q.size()); rx_q.delete(); end
    repeat (5) @(negedge clk);
    test_digit(4'd9);
  endtask

  task automatic test_back_to_back();
    int busy, t;
    push_key(key_tab[1]);
    push_key(key_tab[1]);
    @(negedge clk);
    bus.digit = 4'd1; bus.send = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_accept ready=%b exp=0", bus.ready); end
    wait_idle(busy);
    n_cmp++; if (busy != BUSY) begin n_err++; $display("FAIL b2b_busy1 got=%0d exp=%0d", busy, BUSY); end
    @(negedge clk);
    bus.send = 1'b0;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept ready=%b exp=0", bus.ready); end
    wait_idle(t);
    n_cmp++; if (t != BUSY) begin n_err++; $display("FAIL b2b_busy2 got=%0d exp=%0d", t, BUSY); end
    exp_last = key_tab[1];
    repeat (2) @(negedge clk);
    check_frames("b2b");
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 10; d++) test_digit(4'(d));
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_digit_tx.md
# ps2_digit_tx

PS/2 device-side transmitter that emits the keyboard scan-code sequence for one decimal digit key (0-9) on a PS/2 clock/data pair. It is the inverse of the digit keycode decoder and drives the keyboard input path with scripted keystrokes for self-test and demo playback, without a physical keyboard. Each request sends the make code, then the break sequence (0xF0, code), using 11-bit PS/2 frames.

## Interface
- HALF_CYCLES, 2500: system clocks per PS/2 clock half-period (100 MHz gives 20 kHz); must be at least 2.
- GAP_CYCLES, 5000: idle clocks, with ps2_clk and ps2_data high, after every frame; must be at least 1.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- digit  in  4  digit to send, valid values 0-9.
- send  in  1  request; sampled only while ready=1.
- ready  out  1  high when idle and able to accept a request.
- err  out  1  one-cycle pulse when a request has digit > 9.
- ps2_clk  out  1  PS/2 clock; idles high.
- ps2_data  out  1  PS/2 data; idles high.
- last_code  out  8  scan code of the most recently accepted digit.

## Operation
- Scan-code map, digit to code:
  - 0→0x45, 1→0x16, 2→0x1E, 3→0x26, 4→0x25
  - 5→0x2E, 6→0x36, 7→0x3D, 8→0x3E, 9→0x46
- A request is accepted when ready=1, send=1 and digit≤9. On acceptance, last_code is updated and the byte sequence is latched.
- Byte sequence: code, 0xF0, code.
- Frame format, 11 bits in order:
  - start bit 0
  - 8 data bits, LSB first
  - odd parity bit = ~^data
  - stop bit 1
- Parity examples: 0x45→0, 0xF0→1, 0x16→0.
- States:
  - IDLE: ready=1.
  - BIT_HI: ps2_clk=1 for HALF_CYCLES; ps2_data changes on entry.
  - BIT_LO: ps2_clk=0 for HALF_CYCLES; ps2_data held.
  - GAP: both lines high for GAP_CYCLES.
- Transitions:
  - IDLE→BIT_HI on acceptance.
  - BIT_HI→BIT_LO when the half-period counter expires.
  - BIT_LO→BIT_HI for the next bit while bit index < 10.
  - BIT_LO→GAP after bit 10.
  - GAP→BIT_HI while bytes remain.
  - GAP→IDLE after the last byte.
- Request with digit > 9 while ready=1:
  - err=1 for exactly one cycle.
  - No frame is sent; ready stays 1; last_code is unchanged.
- send while ready=0: ignored. There is no queue and err stays 0.
- send held high through completion: the request is re-accepted on the first cycle ready=1. This is back-to-back keystrokes by design.
- Counters:
  - half-period counter: $clog2(HALF_CYCLES) bits
  - gap counter: $clog2(GAP_CYCLES) bits
  - bit index: 4 bits
  - byte index: 2 bits
  - No wrap-around is reachable.

## Timing
- Reset values: ready=1, err=0, ps2_clk=1, ps2_data=1, last_code=0x00, state IDLE.
- Reset mid-frame: outputs return to reset values on the cycle after reset is sampled high, and the remainder of the frame is discarded. Reset has priority over send.
- Let T be the acceptance cycle and H = HALF_CYCLES.
  - T+1: ready=0, ps2_data=0 (start bit), ps2_clk=1.
  - Bit i (0..10) of byte 0 drives ps2_data from T+1+2iH.
  - ps2_clk is low over [T+1+(2i+1)H, T+1+(2i+2)H).
- Frame length is 22H cycles, followed by GAP_CYCLES of idle.
- ready returns to 1 at T+1+3·(22H+GAP_CYCLES).
- ps2_data is stable for the whole low phase of ps2_clk, so the host samples on the falling edge.
- err asserts at T+1 for an invalid digit, for one cycle.

## Configuration
- PS2_DIGIT_TX_BREAK_EN defined: sequence is code, 0xF0, code (3 frames), as above.
- Macro undefined:
  - Only the make code is sent (1 frame).
  - ready returns at T+1+22H+GAP_CYCLES.
  - Byte-index logic and the 0xF0 constant are not compiled.

## Structure
- Package ps2_pkg holds:
  - constants KEY_0..KEY_9
  - PS2_BREAK = 8'hF0
  - PS2_FRAME_BITS = 11
  - the state enum (IDLE, BIT_HI, BIT_LO, GAP)
  - the digit→code function
- Sub-module ps2_byte_tx serialises one byte, with start/send and done signals, and owns BIT_HI, BIT_LO and GAP.
- ps2_digit_tx owns code lookup, acceptance, err, and byte sequencing.

## Test plan
All scenarios use HALF_CYCLES=4 and GAP_CYCLES=8, with the macro defined unless stated.
- Reset, then idle for 50 cycles → ready=1, ps2_clk=1, ps2_data=1, err=0, last_code=0x00.
- send=1 with digit=0 for one cycle → host-model captures 0x45, 0xF0, 0x45 with parity bits 0, 1, 0. ready=0 for 3·(88+8)=288 cycles. last_code=0x45.
- digit=7 → captures 0x3D, 0xF0, 0x3D. ps2_data is unchanged in every low phase of ps2_clk.
- digit=12 with send=1 → err high for exactly 1 cycle, no ps2_clk edges, ready stays 1.
- Accept digit=3, assert reset at cycle 40 → next cycle ps2_clk=1, ps2_data=1, ready=1. A following digit=9 request sends 0x46 cleanly.
- Macro undefined, digit=5 → a single frame 0x2E, and ready is back high 96 cycles after acceptance.
